inst_queue: RTL and testbench

INST_QUEUE -- requirements
Module: inst_queue

---
 rtl/inst_queue_pkg.sv | 42 ++++
 rtl/inst_queue_ram.sv | 42 ++++
 rtl/inst_queue.sv | 147 ++++++++++++++
 tb/tb_inst_queue.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/inst_queue_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : inst_queue_pkg
//  Description : Shared IF/ID definitions for the instruction queue: default
//                depth, pointer width, 65-bit entry layout (pc, inst, excp)
//                with its field offsets, and a helper that packs one entry.
//  Ports       : none (package)
//  Revision    : 1.0 - initial release
// ============================================================================
package inst_queue_pkg;

  localparam int c_iq_depth_def = 8;
  localparam int c_iq_ptr_w     = $clog2(c_iq_depth_def);
  localparam int c_iq_entry_w   = 65;

  // Entry bit layout, LSB first: excp, then inst, then pc.
  localparam int c_iq_excp_bit  = 0;
  localparam int c_iq_inst_lsb  = 1;
  localparam int c_iq_pc_lsb    = 33;

  // Packed so that the member order matches the offsets above.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        excp;
  } iq_entry_t;

  function automatic logic [c_iq_entry_w-1:0] iq_pack(
    input logic [31:0] pc,
    input logic [31:0] inst,
    input logic        excp
  );
    logic [c_iq_entry_w-1:0] e;
    e                         = '0;
    e[c_iq_pc_lsb +: 32]      = pc;
    e[c_iq_inst_lsb +: 32]    = inst;
    e[c_iq_excp_bit]          = excp;
    return e;
  endfunction

endpackage
`default_nettype wire

// File: rtl/inst_queue_ram.sv
`default_nettype none
// ============================================================================
//  Module      : inst_queue_ram
//  Description : DEPTH x 65-bit entry storage, two synchronous write ports and
//                two asynchronous read ports. No reset on the array.
//  Ports       : clk                        - write clock
//                i_we_n / i_waddr_n / i_wdata_n - write port n (n = 1, 2)
//                i_raddr_n / o_rdata_n      - combinational read port n
//  Revision    : 1.0 - initial release
// ============================================================================
module inst_queue_ram
  import inst_queue_pkg::*;
#(
  parameter int DEPTH = c_iq_depth_def,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic                    clk,
  input  logic                    i_we_1,
  input  logic [PTR_W-1:0]        i_waddr_1,
  input  logic [c_iq_entry_w-1:0] i_wdata_1,
  input  logic                    i_we_2,
  input  logic [PTR_W-1:0]        i_waddr_2,
  input  logic [c_iq_entry_w-1:0] i_wdata_2,
  input  logic [PTR_W-1:0]        i_raddr_1,
  output logic [c_iq_entry_w-1:0] o_rdata_1,
  input  logic [PTR_W-1:0]        i_raddr_2,
  output logic [c_iq_entry_w-1:0] o_rdata_2
);

  logic [c_iq_entry_w-1:0] r_mem [DEPTH];

  // The two write addresses are always tail and tail+1, so they never collide.
  always_ff @(posedge clk) begin
    if (i_we_1) r_mem[i_waddr_1] <= i_wdata_1;
    if (i_we_2) r_mem[i_waddr_2] <= i_wdata_2;
  end

  assign o_rdata_1 = r_mem[i_raddr_1];
  assign o_rdata_2 = r_mem[i_raddr_2];

endmodule
`default_nettype wire

// File: rtl/inst_queue.sv
`default_nettype none
// ============================================================================
//  Module      : inst_queue
//  Description : Two-wide instruction queue between fetch and decode.
//                Circular buffer with head/tail pointers and an entry count.
//                Optional macro INST_QUEUE_BYPASS_EN: when the queue is empty,
//                fetch data is forwarded straight to the decode outputs.
//  Ports       : clk, rst_n (async, active-low), flush
//                w_ena_1/2, w_pc_1/2, w_inst_1/2, w_excp_1/2 - fetch writes
//                r_ena_1/2                                 - decode consumes
//                r_valid_1/2, r_pc_1/2, r_inst_1/2, r_excp_1/2 - head entries
//                full (< 2 free entries), empty (no entries)
//  Revision    : 1.0 - initial release
// ============================================================================
module inst_queue
  import inst_queue_pkg::*;
#(
  parameter int DEPTH = c_iq_depth_def
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  input  logic        w_ena_1,
  input  logic        w_ena_2,
  input  logic [31:0] w_pc_1,
  input  logic [31:0] w_pc_2,
  input  logic [31:0] w_inst_1,
  input  logic [31:0] w_inst_2,
  input  logic        w_excp_1,
  input  logic        w_excp_2,
  input  logic        r_ena_1,
  input  logic        r_ena_2,
  output logic        r_valid_1,
  output logic        r_valid_2,
  output logic [31:0] r_pc_1,
  output logic [31:0] r_pc_2,
  output logic [31:0] r_inst_1,
  output logic [31:0] r_inst_2,
  output logic        r_excp_1,
  output logic        r_excp_2,
  output logic        full,
  output logic        empty
);

  localparam int                 c_ptr_w    = $clog2(DEPTH);
  localparam int                 c_cnt_w    = c_ptr_w + 1;
  localparam logic [c_cnt_w-1:0] c_full_thr = c_cnt_w'(DEPTH - 2);

  logic [c_ptr_w-1:0]      r_head;
  logic [c_ptr_w-1:0]      r_tail;
  logic [c_cnt_w-1:0]      r_count;

  logic [c_ptr_w-1:0]      w_head_p1;
  logic [c_ptr_w-1:0]      w_tail_p1;
  logic [c_iq_entry_w-1:0] w_rdata_1;
  logic [c_iq_entry_w-1:0] w_rdata_2;
  iq_entry_t               w_out_1;
  iq_entry_t               w_out_2;
  logic                    w_v1;
  logic                    w_v2;
  logic                    w_full;
  logic                    w_we_1;
  logic                    w_we_2;
  logic [1:0]              w_pops;
  logic [1:0]              w_pushes;

  assign w_head_p1 = r_head + c_ptr_w'(1);
  assign w_tail_p1 = r_tail + c_ptr_w'(1);

  // Full looks only at the registered count so fetch never depends on decode.
  assign w_full = (r_count > c_full_thr);

  // Dropped writes while full: fetch is expected to hold and retry.
  assign w_we_1   = w_ena_1 & ~w_full & ~flush;
  assign w_we_2   = w_we_1 & w_ena_2;
  assign w_pushes = {1'b0, w_we_1} + {1'b0, w_we_2};

  // r_ena_2 alone is ignored; slot 2 only pops together with slot 1.
  assign w_pops = {1'b0, r_ena_1 & w_v1} + {1'b0, r_ena_1 & r_ena_2 & w_v2};

  inst_queue_ram #(
    .DEPTH (DEPTH),
    .PTR_W (c_ptr_w)
  ) u_ram (
    .clk       (clk),
    .i_we_1    (w_we_1),
    .i_waddr_1 (r_tail),
    .i_wdata_1 (iq_pack(w_pc_1, w_inst_1, w_excp_1)),
    .i_we_2    (w_we_2),
    .i_waddr_2 (w_tail_p1),
    .i_wdata_2 (iq_pack(w_pc_2, w_inst_2, w_excp_2)),
    .i_raddr_1 (r_head),
    .o_rdata_1 (w_rdata_1),
    .i_raddr_2 (w_head_p1),
    .o_rdata_2 (w_rdata_2)
  );

  always_comb begin
    w_v1    = (r_count != '0);
    w_v2    = (r_count > c_cnt_w'(1));
    w_out_1 = iq_entry_t'(w_rdata_1);
    w_out_2 = iq_entry_t'(w_rdata_2);
`ifdef INST_QUEUE_BYPASS_EN
    // Empty queue: forward fetch data. Bypassed entries are still written at
    // tail, but head advances past any that are popped this cycle, so only
    // the unpopped ones remain queued.
    if ((r_count == '0) && !flush && rst_n) begin
      w_v1    = w_ena_1;
      w_v2    = w_ena_2;
      w_out_1 = iq_entry_t'(iq_pack(w_pc_1, w_inst_1, w_excp_1));
      w_out_2 = iq_entry_t'(iq_pack(w_pc_2, w_inst_2, w_excp_2));
    end
`endif
    // Invalid slots present zeros rather than stale storage.
    if (!w_v1) w_out_1 = '0;
    if (!w_v2) w_out_2 = '0;
  end

  assign r_valid_1 = w_v1;
  assign r_valid_2 = w_v2;
  assign r_pc_1    = w_out_1.pc;
  assign r_pc_2    = w_out_2.pc;
  assign r_inst_1  = w_out_1.inst;
  assign r_inst_2  = w_out_2.inst;
  assign r_excp_1  = w_out_1.excp;
  assign r_excp_2  = w_out_2.excp;
  assign full      = w_full;
  assign empty     = (r_count == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (flush) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      r_head  <= r_head + c_ptr_w'(w_pops);
      r_tail  <= r_tail + c_ptr_w'(w_pushes);
      r_count <= r_count + c_cnt_w'(w_pushes) - c_cnt_w'(w_pops);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_inst_queue.sv
`default_nettype none
// ============================================================================
//  Module      : tb_inst_queue
//  Description : Self-checking bench for inst_queue (DEPTH = 8). A vector
//                table drives single cycles with constant expectations; a
//                scoreboard queue holds every accepted entry and checks the
//                data that decode consumes. Hand-written sequences cover the
//                multi-cycle corners. Honours INST_QUEUE_BYPASS_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_inst_queue;

  localparam int c_depth = 8;

  logic        clk = 1'b0;
  logic        rst_n, flush;
  logic        w_ena_1, w_ena_2, w_excp_1, w_excp_2, r_ena_1, r_ena_2;
  logic [31:0] w_pc_1, w_pc_2, w_inst_1, w_inst_2;
  logic        r_valid_1, r_valid_2, r_excp_1, r_excp_2, full, empty;
  logic [31:0] r_pc_1, r_pc_2, r_inst_1, r_inst_2;

  inst_queue #(.DEPTH(c_depth)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .w_ena_1(w_ena_1), .w_ena_2(w_ena_2),
    .w_pc_1(w_pc_1), .w_pc_2(w_pc_2), .w_inst_1(w_inst_1), .w_inst_2(w_inst_2),
    .w_excp_1(w_excp_1), .w_excp_2(w_excp_2),
    .r_ena_1(r_ena_1), .r_ena_2(r_ena_2),
    .r_valid_1(r_valid_1), .r_valid_2(r_valid_2),
    .r_pc_1(r_pc_1), .r_pc_2(r_pc_2), .r_inst_1(r_inst_1), .r_inst_2(r_inst_2),
    .r_excp_1(r_excp_1), .r_excp_2(r_excp_2),
    .full(full), .empty(empty)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        excp;
  } ent_t;

  // ctl = {we1, we2, re1, re2, flush}; ef = {valid1, valid2, full, empty}
  typedef struct {
    logic [4:0] ctl;
    logic [3:0] ef;
    int         cnt;
  } vec_t;

  ent_t        sb[$];
  vec_t        vt[13];
  int          n_checks = 0;
  int          n_pass   = 0;
  logic [31:0] next_pc  = 32'h8000_0000;
  logic [31:0] exp_out_pc;
  logic        seq_en   = 1'b0;

  function automatic logic [31:0] inst_of(input logic [31:0] pc);
    return pc ^ 32'h2400_5A5A;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b expected %b", nm, act, exp);
  endtask

  task automatic idle();
    w_ena_1 = 1'b0; w_ena_2 = 1'b0; r_ena_1 = 1'b0; r_ena_2 = 1'b0; flush = 1'b0;
    w_excp_1 = 1'b0; w_excp_2 = 1'b0;
    w_pc_1 = '0; w_pc_2 = '0; w_inst_1 = '0; w_inst_2 = '0;
  endtask

  // One clock cycle: called at a negedge, returns at the next negedge with
  // inputs idle. acc = number of entries the model says were accepted.
  task automatic cyc(input logic we1, input logic we2, input logic re1,
                     input logic re2, input logic fl, output int acc);
    int   n_pop;
    int   n_push;
    ent_t e;
    w_ena_1 = we1; w_ena_2 = we2; r_ena_1 = re1; r_ena_2 = re2; flush = fl;
    w_pc_1  = next_pc;          w_inst_1 = inst_of(next_pc);          w_excp_1 = next_pc[3];
    w_pc_2  = next_pc + 32'd4;  w_inst_2 = inst_of(next_pc + 32'd4);  w_excp_2 = ~next_pc[3];
    #1;
    n_pop  = 0;
    n_push = 0;
    if (!fl) begin
      if (re1 && sb.size() >= 1) n_pop = (re2 && sb.size() >= 2) ? 2 : 1;
      if (we1 && sb.size() <= c_depth - 2) n_push = we2 ? 2 : 1;
    end
    if (n_pop >= 1) begin
      chk("pop1_pc", r_pc_1, sb[0].pc);
      chk("pop1_inst", r_inst_1, sb[0].inst);
      chk1("pop1_excp", r_excp_1, sb[0].excp);
      if (seq_en) begin
        chk("seq_pc1", r_pc_1, exp_out_pc);
        exp_out_pc = exp_out_pc + 32'd4;
      end
    end
    if (n_pop == 2) begin
      chk("pop2_pc", r_pc_2, sb[1].pc);
      chk("pop2_inst", r_inst_2, sb[1].inst);
      chk1("pop2_excp", r_excp_2, sb[1].excp);
      if (seq_en) begin
        chk("seq_pc2", r_pc_2, exp_out_pc);
        exp_out_pc = exp_out_pc + 32'd4;
      end
    end
    @(posedge clk);
    #1;
    idle();
    if (fl) sb.delete();
    for (int k = 0; k < n_pop; k++) void'(sb.pop_front());
    for (int k = 0; k < n_push; k++) begin
      e.pc   = next_pc;
      e.inst = inst_of(next_pc);
      e.excp = (k == 0) ? next_pc[3] : ~(next_pc - 32'd4) >> 3;
      e.excp = (k == 0) ? w_excp_of(next_pc, 1'b0) : w_excp_of(next_pc - 32'd4, 1'b1);
      sb.push_back(e);
      next_pc = next_pc + 32'd4;
    end
    acc = n_push;
    @(negedge clk);
  endtask

  // Slot-1 excp is pc[3] of the pair base; slot-2 excp is its inverse.
  function automatic logic w_excp_of(input logic [31:0] base, input logic slot2);
    return slot2 ? ~base[3] : base[3];
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int acc;
    int pairs;

    vt[0]  = '{5'b11000, 4'b1100, 2};
    vt[1]  = '{5'b11000, 4'b1100, 4};
    vt[2]  = '{5'b11000, 4'b1100, 6};
    vt[3]  = '{5'b11000, 4'b1110, 8};
    vt[4]  = '{5'b11000, 4'b1110, 8};
    vt[5]  = '{5'b00100, 4'b1110, 7};
    vt[6]  = '{5'b00010, 4'b1110, 7};
    vt[7]  = '{5'b00110, 4'b1100, 5};
    vt[8]  = '{5'b10110, 4'b1100, 4};
    vt[9]  = '{5'b11100, 4'b1100, 5};
    vt[10] = '{5'b10101, 4'b0001, 0};
    vt[11] = '{5'b10000, 4'b1000, 1};
    vt[12] = '{5'b00110, 4'b0001, 0};

    idle();
    rst_n = 1'b0;
    #3;
    chk1("rst_valid1", r_valid_1, 1'b0);
    chk1("rst_valid2", r_valid_2, 1'b0);
    chk1("rst_empty", empty, 1'b1);
    chk1("rst_full", full, 1'b0);
    chk("rst_pc1", r_pc_1, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Push-and-read with fixed boot vectors.
    w_ena_1 = 1'b1; w_ena_2 = 1'b1;
    w_pc_1  = 32'hBFC0_0000; w_inst_1 = 32'h2408_0001;
    w_pc_2  = 32'hBFC0_0004; w_inst_2 = 32'h2409_0002;
`ifndef INST_QUEUE_BYPASS_EN
    #1;
    chk1("lat_valid1_same_cycle", r_valid_1, 1'b0);
`endif
    @(posedge clk);
    #1;
    idle();
    @(negedge clk);
    chk1("boot_valid1", r_valid_1, 1'b1);
    chk1("boot_valid2", r_valid_2, 1'b1);
    chk("boot_pc1", r_pc_1, 32'hBFC0_0000);
    chk("boot_inst1", r_inst_1, 32'h2408_0001);
    chk("boot_pc2", r_pc_2, 32'hBFC0_0004);
    chk("boot_inst2", r_inst_2, 32'h2409_0002);
    chk("boot_count", 32'(dut.r_count), 32'd2);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, acc);
    chk1("boot_flush_empty", empty, 1'b1);

    // Table: fill to full, drop, pops, illegal pop, flush priority.
    for (int i = 0; i < 13; i++) begin
      cyc(vt[i].ctl[4], vt[i].ctl[3], vt[i].ctl[2], vt[i].ctl[1], vt[i].ctl[0], acc);
      chk1($sformatf("v%0d_valid1", i), r_valid_1, vt[i].ef[3]);
      chk1($sformatf("v%0d_valid2", i), r_valid_2, vt[i].ef[2]);
      chk1($sformatf("v%0d_full", i), full, vt[i].ef[1]);
      chk1($sformatf("v%0d_empty", i), empty, vt[i].ef[0]);
      chk($sformatf("v%0d_count", i), 32'(dut.r_count), 32'(vt[i].cnt));
      if (vt[i].ef[3] == 1'b0) chk($sformatf("v%0d_pc1_zero", i), r_pc_1, 32'h0);
    end

    // Illegal pop (r_ena_2 alone) at count 3.
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, acc);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, acc);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, acc);
    chk("illegal_pop_count", 32'(dut.r_count), 32'd3);
    chk("illegal_pop_head_pc", r_pc_1, sb[0].pc);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, acc);

    // Wrap stream: 20 accepted dual pushes, alternating dual/single pops.
    seq_en     = 1'b1;
    exp_out_pc = next_pc;
    pairs      = 0;
    for (int i = 0; i < 300; i++) begin
      if (pairs >= 20 && sb.size() == 0) break;
      cyc(pairs < 20, pairs < 20, sb.size() > 0, i[0], 1'b0, acc);
      if (acc == 2) pairs++;
    end
    seq_en = 1'b0;
    chk("wrap_pairs", 32'(pairs), 32'd20);
    chk("wrap_out_end", exp_out_pc, next_pc);
    chk1("wrap_empty", empty, 1'b1);

    // Asynchronous reset mid-cycle at count 6.
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, acc);
    chk("arst_pre_count", 32'(dut.r_count), 32'd6);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk1("arst_valid1", r_valid_1, 1'b0);
    chk1("arst_valid2", r_valid_2, 1'b0);
    chk1("arst_empty", empty, 1'b1);
    chk1("arst_full", full, 1'b0);
    chk("arst_pc1", r_pc_1, 32'h0);
    chk("arst_inst2", r_inst_2, 32'h0);
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, acc);
    chk1("post_rst_valid2", r_valid_2, 1'b0);
    chk("post_rst_pc1", r_pc_1, sb[0].pc);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, acc);
    chk1("post_rst_drained", empty, 1'b1);

`ifdef INST_QUEUE_BYPASS_EN
    // Bypass: push while empty with a same-cycle pop never enters the queue.
    w_ena_1 = 1'b1; r_ena_1 = 1'b1;
    w_pc_1 = 32'h1234_5678; w_inst_1 = 32'hCAFE_0001; w_excp_1 = 1'b1;
    #1;
    chk1("byp_valid1", r_valid_1, 1'b1);
    chk1("byp_valid2", r_valid_2, 1'b0);
    chk("byp_pc1", r_pc_1, 32'h1234_5678);
    chk("byp_inst1", r_inst_1, 32'hCAFE_0001);
    @(posedge clk);
    #1;
    idle();
    @(negedge clk);
    chk("byp_count", 32'(dut.r_count), 32'd0);
    chk1("byp_empty", empty, 1'b1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
